fp16_vec_accum: RTL and testbench

// - Downstream consumer of the FP8 scalar-by-vector multiply pipe. Each beat carries four FP16 products (qa..qd).
// - Sums the four lanes of every beat exactly in fixed point and accumulates across the beats of a group.
// - A group ends on the beat flagged in_last. The block then emits one FP16 dot-product result, rounded once.
// - No backpressure: the block accepts a beat on every cycle in which in_valid=1, matching the upstream pipe.

---
 rtl/fp16_pkg.sv | 19 +
 rtl/fp16_to_fixed.sv | 30 +++
 rtl/fp16_vec_accum.sv | 247 ++++++++++++++++++++++++
 tb/tb_fp16_vec_accum.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 field layout and fixed-point scaling constants for the
// vector accumulator datapath.
package fp16_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_BIAS  = 15;
    localparam int FIX_FRAC   = 24;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_MAN_W-1:0] man;
    } fp16_t;

endpackage

// File: rtl/fp16_to_fixed.sv
// Exact FP16 to signed fixed-point conversion, value scaled by 2^24.
// Inf/NaN lanes flag is_special_o and contribute zero.
module fp16_to_fixed
    import fp16_pkg::*;
#(
    parameter int ACC_W = 56
) (
    input  logic [15:0]             h_i,
    output logic signed [ACC_W-1:0] val_o,
    output logic                    is_special_o
);

    fp16_t            h;
    logic [ACC_W-1:0] mag;

    assign h            = fp16_t'(h_i);
    assign is_special_o = (h.exp == '1);

    // 2^24 scaling makes the subnormal unit exactly 1, so normals shift by exp-1.
    always_comb begin
        mag = '0;
        if (h.exp == '0) begin
            mag = ACC_W'(h.man);
        end else if (h.exp != '1) begin
            mag = ACC_W'({1'b1, h.man}) << (h.exp - 1'b1);
        end
        val_o = h.sign ? -$signed(mag) : $signed(mag);
    end

endmodule

// File: rtl/fp16_vec_accum.sv
// Four-lane FP16 dot-product accumulator: exact fixed-point group sums,
// one RNE rounding to FP16 per group, three-stage pipeline, no backpressure.
module fp16_vec_accum
    import fp16_pkg::*;
#(
    parameter int ACC_W = 56,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [15:0]      qa,
    input  logic [15:0]      qb,
    input  logic [15:0]      qc,
    input  logic [15:0]      qd,
    output logic             out_valid,
    output logic [15:0]      out_sum,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_nan,
    output logic             out_ovf
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;
    localparam int         EXT_W    = ACC_W + 2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // Signed fixed point to FP16 with round-to-nearest-even.
    function automatic logic [15:0] fix_to_fp16(input logic signed [ACC_W-1:0] a);
        logic             sgn;
        logic [ACC_W-1:0] mag;
        logic [EXT_W-1:0] ext;
        logic [EXT_W-1:0] mask;
        logic [12:0]      shf;
        logic [10:0]      sig;
        logic             guard, rnd, sticky, up;
        logic [11:0]      sig_r;
        int               lead, sh, e;
        fp16_t            res;

        sgn  = a[ACC_W-1];
        mag  = sgn ? $unsigned(-a) : $unsigned(a);
        lead = 0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag[i]) lead = i;
        end
        res = '0;
        if (mag == '0) begin
            res = '0;
        end else if (lead < FP16_MAN_W) begin
            // Below 2^-14 the fixed-point LSB equals the subnormal LSB: exact.
            res.sign = sgn;
            res.exp  = '0;
            res.man  = mag[FP16_MAN_W-1:0];
        end else begin
            sh     = lead - FP16_MAN_W;
            ext    = {mag, 2'b00};
            shf    = 13'(ext >> sh);
            mask   = (EXT_W'(1) << sh) - EXT_W'(1);
            sig    = shf[12:2];
            guard  = shf[1];
            rnd    = shf[0];
            sticky = |(ext & mask);
            up     = guard & (rnd | sticky | sig[0]);
            sig_r  = {1'b0, sig} + 12'(up);
            e      = lead - FIX_FRAC + FP16_BIAS + (sig_r[11] ? 1 : 0);
            if (e >= 31) begin
                res = {sgn, FP16_PINF[14:0]};
            end else begin
                res.sign = sgn;
                res.exp  = e[4:0];
                res.man  = sig_r[11] ? sig_r[10:1] : sig_r[9:0];
            end
        end
        return res;
    endfunction

    logic [15:0]             lane_in   [4];
    logic signed [ACC_W-1:0] lane_fix  [4];
    logic [3:0]              lane_spec;

    assign lane_in[0] = qa;
    assign lane_in[1] = qb;
    assign lane_in[2] = qc;
    assign lane_in[3] = qd;

    for (genvar g = 0; g < 4; g++) begin : g_cvt
        fp16_to_fixed #(.ACC_W(ACC_W)) u_cvt (
            .h_i          (lane_in[g]),
            .val_o        (lane_fix[g]),
            .is_special_o (lane_spec[g])
        );
    end

    // Stage S1: converted lanes.
    logic signed [ACC_W-1:0] s1_lane_q [4];
    logic [3:0]              s1_spec_q;
    logic                    s1_vld_q;
    logic                    s1_last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_spec_q <= '0;
            for (int i = 0; i < 4; i++) s1_lane_q[i] <= '0;
        end else begin
            s1_vld_q  <= in_valid;
            s1_last_q <= in_valid & in_last;
            if (in_valid) begin
                s1_spec_q <= lane_spec;
                for (int i = 0; i < 4; i++) s1_lane_q[i] <= lane_fix[i];
            end
        end
    end

    // Stage S2: lane sum and group accumulation.
    logic [0:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    nan_q, nan_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] beat_sum, acc_add;
    logic signed [ACC_W-1:0] grp_acc;
    logic [CNT_W-1:0]        grp_cnt;
    logic                    grp_nan, grp_ovf, add_ovf;

    logic                    fin_vld_q;
    logic signed [ACC_W-1:0] fin_acc_q;
    logic [CNT_W-1:0]        fin_cnt_q;
    logic                    fin_nan_q;
    logic                    fin_ovf_q;

    assign beat_sum = s1_lane_q[0] + s1_lane_q[1] + s1_lane_q[2] + s1_lane_q[3];
    assign acc_add  = acc_q + beat_sum;
    assign add_ovf  = (acc_q[ACC_W-1] == beat_sum[ACC_W-1]) &&
                      (acc_add[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        if (state_q == ST_IDLE) begin
            grp_acc = beat_sum;
            grp_cnt = CNT_W'(1);
            grp_nan = |s1_spec_q;
            grp_ovf = 1'b0;
        end else begin
            grp_acc = acc_add;
            grp_cnt = sat_inc(cnt_q);
            grp_nan = nan_q | (|s1_spec_q);
            grp_ovf = ovf_q | add_ovf;
        end

        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        nan_d   = nan_q;
        ovf_d   = ovf_q;
        if (s1_vld_q) begin
            if (s1_last_q) begin
                // Group closes: results move to S3, accumulator is free next cycle.
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                nan_d   = 1'b0;
                ovf_d   = 1'b0;
            end else begin
                state_d = ST_ACCUM;
                acc_d   = grp_acc;
                cnt_d   = grp_cnt;
                nan_d   = grp_nan;
                ovf_d   = grp_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            nan_q     <= 1'b0;
            ovf_q     <= 1'b0;
            fin_vld_q <= 1'b0;
            fin_acc_q <= '0;
            fin_cnt_q <= '0;
            fin_nan_q <= 1'b0;
            fin_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            nan_q     <= nan_d;
            ovf_q     <= ovf_d;
            fin_vld_q <= s1_vld_q & s1_last_q;
            if (s1_vld_q && s1_last_q) begin
                fin_acc_q <= grp_acc;
                fin_cnt_q <= grp_cnt;
                fin_nan_q <= grp_nan;
                fin_ovf_q <= grp_ovf;
            end
        end
    end

    // Stage S3: normalize, round and present the group result.
    logic             out_vld_q;
    logic [15:0]      out_sum_q, res_d;
    logic [CNT_W-1:0] out_beats_q;
    logic             out_nan_q, out_ovf_q;

    always_comb begin
        if (fin_nan_q) begin
            res_d = FP16_QNAN;
        end else if (fin_ovf_q) begin
            res_d = {fin_acc_q[ACC_W-1], FP16_PINF[14:0]};
        end else begin
            res_d = fix_to_fp16(fin_acc_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld_q   <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
            out_nan_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_vld_q <= fin_vld_q;
            if (fin_vld_q) begin
                out_sum_q   <= res_d;
                out_beats_q <= fin_cnt_q;
                out_nan_q   <= fin_nan_q;
                out_ovf_q   <= fin_ovf_q;
            end
        end
    end

    assign out_valid = out_vld_q;
    assign out_sum   = out_sum_q;
    assign out_beats = out_beats_q;
    assign out_nan   = out_nan_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fp16_vec_accum.sv
// Self-checking bench for fp16_vec_accum: directed cases plus randomized groups
// against a value-level reference (exact integer sums, nearest-FP16 search).
module tb_fp16_vec_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last;
    logic [15:0] qa, qb, qc, qd;
    logic        out_valid;
    logic [15:0] out_sum;
    logic [15:0] out_beats;
    logic        out_nan, out_ovf;

    always #5 clk = ~clk;

    fp16_vec_accum #(.ACC_W(56), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .qa        (qa),
        .qb        (qb),
        .qc        (qc),
        .qd        (qd),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_beats (out_beats),
        .out_nan   (out_nan),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        int unsigned cyc;
        logic [15:0] sum;
        logic [15:0] beats;
        logic        nan;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [63:0] v;
        bit          last;
        logic [15:0] sum;
        logic [15:0] beats;
        logic        nan;
    } dir_t;

    localparam longint ACC_MAX = (64'sd1 <<< 55) - 64'sd1;
    localparam longint ACC_MIN = -(64'sd1 <<< 55);
    localparam logic [63:0] SC1 = 64'h4600_C200_4000_C400;

    res_t        obsq[$];
    res_t        expq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;

    longint m_acc;
    int     m_cnt;
    bit     m_open, m_nan, m_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1)
            obsq.push_back('{cyc: cyc, sum: out_sum, beats: out_beats, nan: out_nan, ovf: out_ovf});
    end

    // ---------------- reference model ----------------
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    // Real value of an FP16 code in units of 2^-24 (Inf/NaN contribute nothing).
    function automatic longint h2fix(input logic [15:0] h);
        int  e = int'(h[14:10]);
        int  m = int'(h[9:0]);
        real r;
        if (e == 31) return 0;
        if (e == 0) r = (m / 1024.0) * pow2(-14);
        else        r = (1.0 + m / 1024.0) * pow2(e - 15);
        r = r * pow2(24);
        return h[15] ? -longint'(r) : longint'(r);
    endfunction

    // Code 0x7C00 stands for the first value past the finite range (2^16).
    function automatic longint code_val(input int c);
        if (c >= 32'h7C00) return 64'sd1 <<< 40;
        return h2fix(16'(c));
    endfunction

    // Nearest positive FP16 code by search over the ordered code space, ties to even code.
    function automatic logic [15:0] ref_round(input longint a);
        longint mag = (a < 0) ? -a : a;
        int     lo  = 0;
        int     hi  = 32'h7C00;
        int     mid, c;
        longint dl, dh;
        if (mag == 0) return 16'h0000;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (code_val(mid) <= mag) lo = mid;
            else hi = mid - 1;
        end
        c = lo;
        if (lo < 32'h7C00) begin
            dl = mag - code_val(lo);
            dh = code_val(lo + 1) - mag;
            if (dh < dl || (dh == dl && (lo % 2) == 1)) c = lo + 1;
        end
        return {(a < 0), 15'(c)};
    endfunction

    task automatic model_beat(input logic [63:0] v, input bit last);
        longint s = h2fix(v[63:48]) + h2fix(v[47:32]) + h2fix(v[31:16]) + h2fix(v[15:0]);
        bit     sp = (v[62:58] == 5'h1F) || (v[46:42] == 5'h1F) ||
                     (v[30:26] == 5'h1F) || (v[14:10] == 5'h1F);
        longint t;
        res_t   r;
        if (!m_open) begin
            m_acc = s; m_cnt = 1; m_nan = sp; m_ovf = 1'b0;
        end else begin
            t = m_acc + s;
            if (t > ACC_MAX) begin m_ovf = 1'b1; t = t - (64'sd1 <<< 56); end
            if (t < ACC_MIN) begin m_ovf = 1'b1; t = t + (64'sd1 <<< 56); end
            m_acc = t;
            m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            m_nan = m_nan | sp;
        end
        if (last) begin
            r.cyc   = cyc + 3;
            r.sum   = m_nan ? 16'h7E00 : m_ovf ? {(m_acc < 0), 15'h7C00} : ref_round(m_acc);
            r.beats = 16'(m_cnt);
            r.nan   = m_nan;
            r.ovf   = m_ovf;
            expq.push_back(r);
            m_open = 1'b0;
        end else begin
            m_open = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive_beat(input logic [63:0] v, input bit last);
        @(negedge clk);
        in_valid = 1'b1;
        in_last  = last;
        {qa, qb, qc, qd} = v;
        model_beat(v, last);
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            {qa, qb, qc, qd} = {$urandom, $urandom};
        end
    endtask

    function automatic logic [15:0] rand_lane();
        logic [15:0] h = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 1:    h[14:10] = 5'($urandom_range(0, 3));
            2:       h[14:10] = 5'($urandom_range(0, 31));
            default: h[14:10] = 5'($urandom_range(0, 30));
        endcase
        return h;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_vec++; if (out_sum !== 16'h0) begin n_err++; $display("FAIL reset_sum got %h want 0000", out_sum); end
        n_vec++; if (out_beats !== 16'h0) begin n_err++; $display("FAIL reset_beats got %0d want 0", out_beats); end
        n_vec++; if (out_nan !== 1'b0) begin n_err++; $display("FAIL reset_nan got %b want 0", out_nan); end
        n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
        rst = 1'b1;
        drive_idle(2);
    endtask

    task automatic test_directed();
        dir_t tbl[$];
        dir_t req[$];
        dir_t q;
        res_t o, e;
        tbl.push_back('{SC1, 1'b1, 16'h3C00, 16'd1, 1'b0});
        tbl.push_back('{64'h4080_C480_4200_C600, 1'b0, 16'h0, 16'd0, 1'b0});
        tbl.push_back('{SC1, 1'b1, 16'hC440, 16'd2, 1'b0});
        tbl.push_back('{64'h6800_3C00_0000_0000, 1'b1, 16'h6800, 16'd1, 1'b0});
        tbl.push_back('{64'h6800_4200_0000_0000, 1'b1, 16'h6802, 16'd1, 1'b0});
        tbl.push_back('{64'h0001_0001_0000_0000, 1'b1, 16'h0002, 16'd1, 1'b0});
        tbl.push_back('{64'h4000_C000_0000_0000, 1'b1, 16'h0000, 16'd1, 1'b0});
        tbl.push_back('{64'h7BFF_7BFF_7BFF_7BFF, 1'b1, 16'h7C00, 16'd1, 1'b0});
        tbl.push_back('{64'h7E00_3C00_0000_0000, 1'b1, 16'h7E00, 16'd1, 1'b1});
        tbl.push_back('{64'h0000_7C00_0000_0000, 1'b1, 16'h7E00, 16'd1, 1'b1});
        foreach (tbl[i]) begin
            drive_beat(tbl[i].v, tbl[i].last);
            if (tbl[i].last) begin
                req.push_back(tbl[i]);
                drive_idle(1);
            end
        end
        drive_idle(5);
        foreach (req[k]) begin
            q = req[k];
            e = expq.pop_front();
            n_vec++;
            if (obsq.size() == 0) begin
                n_err++; $display("FAIL directed[%0d] no out_valid pulse, want sum %h", k, q.sum);
            end else begin
                o = obsq.pop_front();
                if ({o.sum, o.beats, o.nan, o.ovf} !== {q.sum, q.beats, q.nan, 1'b0} || o.cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL directed[%0d] got sum=%h beats=%0d nan=%b ovf=%b cyc=%0d want sum=%h beats=%0d nan=%b ovf=0 cyc=%0d",
                             k, o.sum, o.beats, o.nan, o.ovf, o.cyc, q.sum, q.beats, q.nan, e.cyc);
                end
            end
        end
        n_vec++;
        if (obsq.size() != 0) begin n_err++; $display("FAIL directed_extra got %0d unexpected pulses want 0", obsq.size()); end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_back_to_back();
        res_t o, e;
        int unsigned first_cyc = 0;
        repeat (4) drive_beat(SC1, 1'b1);
        drive_idle(5);
        for (int k = 0; k < 4; k++) begin
            e = expq.pop_front();
            if (k == 0) first_cyc = e.cyc;
            n_vec++;
            if (obsq.size() == 0) begin
                n_err++; $display("FAIL b2b[%0d] no out_valid pulse, want 3c00", k);
            end else begin
                o = obsq.pop_front();
                if (o.sum !== 16'h3C00 || o.beats !== 16'd1 || o.nan !== 1'b0 || o.cyc !== first_cyc + k) begin
                    n_err++;
                    $display("FAIL b2b[%0d] got sum=%h beats=%0d nan=%b cyc=%0d want sum=3c00 beats=1 nan=0 cyc=%0d",
                             k, o.sum, o.beats, o.nan, o.cyc, first_cyc + k);
                end
            end
        end
        n_vec++;
        if (obsq.size() != 0) begin n_err++; $display("FAIL b2b_extra got %0d unexpected pulses want 0", obsq.size()); end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_reset_mid_group();
        res_t o, e;
        drive_beat(64'h4080_C480_4200_C600, 1'b0);
        drive_beat(64'h4080_C480_4200_C600, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        m_open   = 1'b0;
        #1;
        n_vec++;
        if (out_sum !== 16'h0 || out_beats !== 16'h0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL async_reset got sum=%h beats=%0d valid=%b want 0000/0/0", out_sum, out_beats, out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        drive_beat(SC1, 1'b1);
        drive_idle(5);
        e = expq.pop_front();
        n_vec++;
        if (obsq.size() == 0) begin
            n_err++; $display("FAIL reset_mid no out_valid pulse, want 3c00");
        end else begin
            o = obsq.pop_front();
            if (o.sum !== 16'h3C00 || o.beats !== 16'd1 || o.cyc !== e.cyc) begin
                n_err++;
                $display("FAIL reset_mid got sum=%h beats=%0d cyc=%0d want sum=3c00 beats=1 cyc=%0d",
                         o.sum, o.beats, o.cyc, e.cyc);
            end
        end
        n_vec++;
        if (obsq.size() != 0) begin n_err++; $display("FAIL reset_mid_extra got %0d unexpected pulses want 0", obsq.size()); end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_overflow();
        res_t o, e;
        for (int i = 0; i < 8200; i++) drive_beat(64'h7BFF_7BFF_7BFF_7BFF, i == 8199);
        drive_idle(5);
        e = expq.pop_front();
        n_vec++;
        if (obsq.size() == 0) begin
            n_err++; $display("FAIL overflow no out_valid pulse, want sum %h", e.sum);
        end else begin
            o = obsq.pop_front();
            if ({o.sum, o.beats, o.nan, o.ovf} !== {e.sum, e.beats, e.nan, e.ovf} || o.cyc !== e.cyc) begin
                n_err++;
                $display("FAIL overflow got sum=%h beats=%0d nan=%b ovf=%b cyc=%0d want sum=%h beats=%0d nan=%b ovf=%b cyc=%0d",
                         o.sum, o.beats, o.nan, o.ovf, o.cyc, e.sum, e.beats, e.nan, e.ovf, e.cyc);
            end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_random();
        res_t o, e;
        int   nb;
        int   k = 0;
        for (int g = 0; g < 60; g++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                drive_beat({rand_lane(), rand_lane(), rand_lane(), rand_lane()}, b == nb - 1);
                if ($urandom_range(0, 3) == 0) drive_idle($urandom_range(1, 2));
            end
        end
        drive_idle(5);
        while (expq.size() != 0) begin
            e = expq.pop_front();
            n_vec++;
            if (obsq.size() == 0) begin
                n_err++; $display("FAIL random[%0d] no out_valid pulse, want sum %h", k, e.sum);
            end else begin
                o = obsq.pop_front();
                if ({o.sum, o.beats, o.nan, o.ovf} !== {e.sum, e.beats, e.nan, e.ovf} || o.cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL random[%0d] got sum=%h beats=%0d nan=%b ovf=%b cyc=%0d want sum=%h beats=%0d nan=%b ovf=%b cyc=%0d",
                             k, o.sum, o.beats, o.nan, o.ovf, o.cyc, e.sum, e.beats, e.nan, e.ovf, e.cyc);
                end
            end
            k++;
        end
        n_vec++;
        if (obsq.size() != 0) begin n_err++; $display("FAIL random_extra got %0d unexpected pulses want 0", obsq.size()); end
        obsq.delete();
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        {qa, qb, qc, qd} = 64'h0;
        m_open = 1'b0; m_nan = 1'b0; m_ovf = 1'b0; m_acc = 0; m_cnt = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_group();
        test_overflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
